// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle control unit and the CPU datapath.
// The MemReady wait input exists only when MC_MEMWAIT_EN is defined.
interface mc_control_fsm_if #(
  parameter int OPW    = 6,
  parameter int ALUOPW = 3
);
`ifdef MC_MEMWAIT_EN
  logic              MemReady;
`endif
  logic [OPW-1:0]    opcode;
  logic              Zero;
  logic              IRWre;
  logic              PCWre;
  logic [1:0]        PCSrc;
  logic              RegWre;
  logic              RegDst;
  logic              ALUSrcB;
  logic              ExtSel;
  logic [ALUOPW-1:0] ALUOp;
  logic              mRD;
  logic              mWR;
  logic              DBDataSrc;
  logic [2:0]        state;

  modport master (
`ifdef MC_MEMWAIT_EN
    input  MemReady,
`endif
    input  opcode, Zero,
    output IRWre, PCWre, PCSrc, RegWre, RegDst, ALUSrcB, ExtSel,
    output ALUOp, mRD, mWR, DBDataSrc, state
  );

  modport slave (
`ifdef MC_MEMWAIT_EN
    output MemReady,
`endif
    output opcode, Zero,
    input  IRWre, PCWre, PCSrc, RegWre, RegDst, ALUSrcB, ExtSel,
    input  ALUOp, mRD, mWR, DBDataSrc, state
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle CPU control unit: IF/ID/EXE/MEM/WB sequencer with combinational output decode.
// Optional MC_MEMWAIT_EN: sIF and sMEM stall until the memory returns MemReady.
module mc_control_fsm #(
  parameter int OPW    = 6,
  parameter int ALUOPW = 3
) (
  input  logic             CLK,
  input  logic             Reset,
  mc_control_fsm_if.master bus
);

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  typedef enum logic [2:0] {
    CL_ALU, CL_LD, CL_ST, CL_BR, CL_J, CL_HALT, CL_UNDEF
  } cls_t;

  typedef struct packed {
    logic [ALUOPW-1:0] op;
    logic              srcb;
    logic              ext;
    logic              rd;
  } alu_ctl_t;

  localparam logic [OPW-1:0] OP_ADD  = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(6'b000001);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b000010);
  localparam logic [OPW-1:0] OP_OR   = OPW'(6'b010000);
  localparam logic [OPW-1:0] OP_AND  = OPW'(6'b010001);
  localparam logic [OPW-1:0] OP_ORI  = OPW'(6'b010010);
  localparam logic [OPW-1:0] OP_SLT  = OPW'(6'b100110);
  localparam logic [OPW-1:0] OP_SW   = OPW'(6'b110000);
  localparam logic [OPW-1:0] OP_LW   = OPW'(6'b110001);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b110100);
  localparam logic [OPW-1:0] OP_J    = OPW'(6'b111000);
  localparam logic [OPW-1:0] OP_HALT = OPW'(6'b111111);

  localparam logic [ALUOPW-1:0] ALU_ADD = ALUOPW'(3'b000);
  localparam logic [ALUOPW-1:0] ALU_SUB = ALUOPW'(3'b001);
  localparam logic [ALUOPW-1:0] ALU_SLT = ALUOPW'(3'b010);
  localparam logic [ALUOPW-1:0] ALU_OR  = ALUOPW'(3'b011);
  localparam logic [ALUOPW-1:0] ALU_AND = ALUOPW'(3'b100);

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  function automatic cls_t op_class(input logic [OPW-1:0] op);
    cls_t c;
    case (op)
      OP_ADD, OP_SUB, OP_ADDI,
      OP_OR, OP_AND, OP_ORI, OP_SLT: c = CL_ALU;
      OP_LW:                         c = CL_LD;
      OP_SW:                         c = CL_ST;
      OP_BEQ:                        c = CL_BR;
      OP_J:                          c = CL_J;
      OP_HALT:                       c = CL_HALT;
      default:                       c = CL_UNDEF;
    endcase
    return c;
  endfunction

  // Immediate forms pick the extended immediate; only addi sign-extends, ori zero-extends.
  function automatic alu_ctl_t alu_decode(input logic [OPW-1:0] op);
    alu_ctl_t d;
    d = '{op: ALU_ADD, srcb: 1'b0, ext: 1'b0, rd: 1'b1};
    case (op)
      OP_SUB:  d.op = ALU_SUB;
      OP_OR:   d.op = ALU_OR;
      OP_AND:  d.op = ALU_AND;
      OP_SLT:  d.op = ALU_SLT;
      OP_ADDI: d = '{op: ALU_ADD, srcb: 1'b1, ext: 1'b1, rd: 1'b0};
      OP_ORI:  d = '{op: ALU_OR,  srcb: 1'b1, ext: 1'b0, rd: 1'b0};
      default: d.op = ALU_ADD;
    endcase
    return d;
  endfunction

  state_t   state_p0;
  cls_t     cls;
  alu_ctl_t alu_ctl;
  logic     mem_go;

`ifdef MC_MEMWAIT_EN
  assign mem_go = bus.MemReady;
`else
  assign mem_go = 1'b1;
`endif

  assign cls     = op_class(bus.opcode);
  assign alu_ctl = alu_decode(bus.opcode);

  // ---- state register: Reset wins over any stall or in-flight instruction
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_p0 <= S_IF;
    end else begin
      unique case (state_p0)
        S_IF:     if (mem_go) state_p0 <= S_ID;
        S_ID: begin
          case (cls)
            CL_ALU:         state_p0 <= S_EXE_AL;
            CL_LD, CL_ST:   state_p0 <= S_EXE_LS;
            CL_BR:          state_p0 <= S_EXE_BR;
            CL_HALT:        state_p0 <= S_ID;
            default:        state_p0 <= S_IF;
          endcase
        end
        S_EXE_AL: state_p0 <= S_WB_AL;
        S_WB_AL:  state_p0 <= S_IF;
        S_EXE_LS: state_p0 <= S_MEM;
        S_MEM:    if (mem_go) state_p0 <= (cls == CL_LD) ? S_WB_LD : S_IF;
        S_WB_LD:  state_p0 <= S_IF;
        S_EXE_BR: state_p0 <= S_IF;
        default:  state_p0 <= S_IF;
      endcase
    end
  end

  logic              irwre_c, pcwre_c, regwre_c, regdst_c, alusrcb_c, extsel_c;
  logic              mrd_c, mwr_c, dbsrc_c;
  logic [1:0]        pcsrc_c;
  logic [ALUOPW-1:0] aluop_c;

  // ---- output decode from the registered state and the IR opcode
  always_comb begin
    irwre_c   = 1'b0;
    pcwre_c   = 1'b0;
    pcsrc_c   = PC_SEQ;
    regwre_c  = 1'b0;
    regdst_c  = 1'b0;
    alusrcb_c = 1'b0;
    extsel_c  = 1'b0;
    aluop_c   = ALU_ADD;
    mrd_c     = 1'b0;
    mwr_c     = 1'b0;
    dbsrc_c   = 1'b0;
    unique case (state_p0)
      S_IF: irwre_c = mem_go;
      S_ID: begin
        // j and undefined opcodes retire here; halt parks with every enable low
        if (cls == CL_J) begin
          pcwre_c = 1'b1;
          pcsrc_c = PC_JMP;
        end else if (cls == CL_UNDEF) begin
          pcwre_c = 1'b1;
        end
      end
      S_EXE_AL, S_WB_AL: begin
        aluop_c   = alu_ctl.op;
        alusrcb_c = alu_ctl.srcb;
        extsel_c  = alu_ctl.ext;
        regdst_c  = alu_ctl.rd;
        if (state_p0 == S_WB_AL) begin
          regwre_c = 1'b1;
          pcwre_c  = 1'b1;
        end
      end
      S_EXE_LS: begin
        alusrcb_c = 1'b1;
        extsel_c  = 1'b1;
      end
      S_MEM: begin
        if (cls == CL_LD) begin
          mrd_c = 1'b1;
        end else if (cls == CL_ST) begin
          mwr_c   = 1'b1;
          pcwre_c = mem_go;
        end
      end
      S_WB_LD: begin
        regwre_c = 1'b1;
        dbsrc_c  = 1'b1;
        pcwre_c  = 1'b1;
      end
      S_EXE_BR: begin
        aluop_c = ALU_SUB;
        pcwre_c = 1'b1;
        pcsrc_c = bus.Zero ? PC_BR : PC_SEQ;
      end
      default: irwre_c = 1'b0;
    endcase
  end

  assign bus.IRWre     = irwre_c;
  assign bus.PCWre     = pcwre_c;
  assign bus.PCSrc     = pcsrc_c;
  assign bus.RegWre    = regwre_c;
  assign bus.RegDst    = regdst_c;
  assign bus.ALUSrcB   = alusrcb_c;
  assign bus.ExtSel    = extsel_c;
  assign bus.ALUOp     = aluop_c;
  assign bus.mRD       = mrd_c;
  assign bus.mWR       = mwr_c;
  assign bus.DBDataSrc = dbsrc_c;
  assign bus.state     = state_p0;

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Multicycle control unit for the CPU core. It sequences each instruction through the fetch, decode, execute, memory and writeback states. It drives the instruction register's IRWre, the PC write enable, the register-file and data-memory strobes, and the datapath mux selects. It sits between the IR output (opcode field) and the ALU Zero flag on one side, and every datapath control input on the other.

Parameters:
OPW, 6, opcode field width (instruction bits [31:26])
ALUOPW, 3, ALU operation select width

Ports:
CLK  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high reset
opcode  in  OPW  IR output bits [31:26]; valid from sID onward
Zero  in  1  ALU zero flag; sampled in sEXE_BR only
IRWre  out  1  IR load enable
PCWre  out  1  PC write enable
PCSrc  out  2  00 PC+4, 01 branch target, 10 jump target
RegWre  out  1  register-file write enable
RegDst  out  1  1 = rd, 0 = rt
ALUSrcB  out  1  1 = extended immediate, 0 = rt data
ExtSel  out  1  1 = sign-extend, 0 = zero-extend
ALUOp  out  ALUOPW  000 add, 001 sub, 010 slt, 011 or, 100 and
mRD  out  1  data-memory read strobe
mWR  out  1  data-memory write strobe
DBDataSrc  out  1  1 = memory data to writeback, 0 = ALU result
state  out  3  current state, for debug

Behaviour:
- Interface: one clock, CLK. Reset is synchronous and active-high. The state register updates on the rising edge of CLK. All other outputs are combinational decode of the registered state and opcode.
- State encoding:
  - sIF=000, sID=001, sEXE_LS=010, sMEM=011
  - sWB_LD=100, sEXE_BR=101, sEXE_AL=110, sWB_AL=111
- Reset:
  - Reset=1 at a clock edge forces state to sIF, whatever state it was in. Any in-flight instruction is abandoned with no writes.
  - Post-reset outputs: IRWre=1, all other enables 0, PCSrc=00, ALUOp=000, selects 0.
- Opcodes:
  - add 000000, sub 000001, addi 000010
  - or 010000, and 010001, ori 010010
  - slt 100110, sw 110000, lw 110001
  - beq 110100, j 111000, halt 111111
- Transitions:
  - sIF→sID, unconditional.
  - sID, by opcode class:
    - R-type, addi, ori → sEXE_AL
    - lw, sw → sEXE_LS
    - beq → sEXE_BR
    - j → sIF, with PCWre=1 and PCSrc=10 in sID
    - halt → stay in sID, with PCWre=0 and no writes, until Reset
    - undefined opcode → sIF, with PCWre=1 and PCSrc=00 (NOP)
  - sEXE_AL→sWB_AL→sIF.
  - sEXE_LS→sMEM. sMEM→sWB_LD for lw, or sMEM→sIF for sw.
  - sWB_LD→sIF.
  - sEXE_BR→sIF.
- Per-state outputs (everything not listed is 0):
  - sIF: IRWre=1.
  - sEXE_AL and sWB_AL: ALUOp, ALUSrcB, ExtSel and RegDst are decoded and held stable across both states.
  - sWB_AL: RegWre=1, PCWre=1, PCSrc=00.
  - sEXE_LS: ALUOp=000, ALUSrcB=1, ExtSel=1.
  - sMEM: mRD=1 for lw. For sw, mWR=1 plus PCWre=1.
  - sWB_LD: RegWre=1, DBDataSrc=1, RegDst=0, PCWre=1.
  - sEXE_BR: ALUOp=001, PCWre=1, PCSrc = Zero ? 01 : 00.
- Latency in cycles: R/addi/ori 4, lw 5, sw 4, beq 3, j 2.
- Invariants:
  - Exactly one PCWre pulse per retired instruction.
  - IRWre is never high in the same cycle as RegWre or mWR.
  - mRD and mWR are never high together.

Optional Feature:
MC_MEMWAIT_EN:
- When defined, adds input MemReady (1 bit).
- sIF holds until MemReady=1. IRWre is asserted only in the cycle MemReady=1, and the transition to sID happens on that edge.
- sMEM holds mRD/mWR until MemReady=1. The sw PCWre pulse is asserted only in the MemReady=1 cycle.
- Reset during a wait returns to sIF immediately.
- When undefined, the port is absent and sIF and sMEM last exactly one cycle.

Test Plan:
- Reset held 2 cycles, then released → state=000, IRWre=1, PCWre=0, RegWre=0, mWR=0.
- opcode=000001 (sub) → states 000,001,110,111,000. ALUOp=001 in sEXE_AL and sWB_AL. RegWre=1, RegDst=1, PCWre=1 in sWB_AL only.
- opcode=110001 (lw) → 5 cycles: 000,001,010,011,100. mRD=1 in sMEM. RegWre=1 and DBDataSrc=1 in sWB_LD. sw (110000) → mWR=1 and PCWre=1 in sMEM, then back to 000.
- opcode=110100 with Zero=1 → PCSrc=01 and PCWre=1 in sEXE_BR. With Zero=0 → PCSrc=00. opcode=111000 → PCSrc=10 and PCWre=1 in sID, 2-cycle instruction.
- opcode=111111 → state stays 001 for 10+ cycles, all enables 0. Reset=1 → state=000 next edge. Reset asserted during sMEM of sw → mWR drops and state=000 next edge.
- MC_MEMWAIT_EN: MemReady=0 for 3 cycles in sIF → state holds 000, IRWre=0. MemReady=1 → IRWre=1, then state=001.
